// File: rtl/skip_block_subtractor.sv
// Multi-cycle subtractor: BLK bits per cycle with a per-block borrow skip, valid/ready handshake on both sides.
// Optional macro SUB_EARLY_DONE_EN finishes early once all remaining operand blocks are zero.
module skip_block_subtractor #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NBLK = WIDTH / BLK;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  logic [KW-1:0]    k;
  int               kk;

  logic [BLK-1:0]   blk_a;
  logic [BLK-1:0]   blk_b;
  logic [BLK-1:0]   blk_d;
  logic             ripple;
  logic             blk_p;
  logic             blk_bout;
  logic [WIDTH-1:0] diff_upd;
  logic [WIDTH-1:0] diff_fill;
  logic             early;
  logic             last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign kk        = int'(k);
  assign last      = (k == KW'(NBLK - 1));

  // Ripple through the current block; P=1 means every bit pair is equal,
  // so the borrow-in passes straight to the block borrow-out.
  always_comb begin
    blk_a  = a_r[kk*BLK +: BLK];
    blk_b  = b_r[kk*BLK +: BLK];
    blk_d  = '0;
    ripple = borrow_r;
    for (int i = 0; i < BLK; i++) begin
      blk_d[i] = blk_a[i] ^ blk_b[i] ^ ripple;
      ripple   = (~blk_a[i] & blk_b[i]) | (~(blk_a[i] ^ blk_b[i]) & ripple);
    end
    blk_p    = &(~(blk_a ^ blk_b));
    blk_bout = blk_p ? borrow_r : ripple;
    diff_upd = diff;
    diff_upd[kk*BLK +: BLK] = blk_d;
  end

`ifdef SUB_EARLY_DONE_EN
  logic [WIDTH-1:0] hi_mask;
  // With all higher operand bits zero, the remaining difference bits are just the borrow.
  assign hi_mask   = {WIDTH{1'b1}} << ((kk + 1) * BLK);
  assign early     = (((a_r | b_r) & hi_mask) == '0);
  assign diff_fill = (diff_upd & ~hi_mask) | ({WIDTH{blk_bout}} & hi_mask);
`else
  assign early     = 1'b0;
  assign diff_fill = diff_upd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      borrow_r <= 1'b0;
      k        <= '0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            k        <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          diff     <= diff_fill;
          borrow_r <= blk_bout;
          k        <= k + 1'b1;
          if (last || early) begin
            bout  <= blk_bout;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
